// File: rtl/rat_rename_ckpt.sv
// ---------------------------------------------------------------------------
// rat_rename_ckpt
// Register alias table for the Tomasulo front end. Renames one decoded
// instruction per cycle, resolves each source to a value or a producer tag
// (with same-cycle CDB bypass), absorbs NUM_CDB broadcasts per cycle and
// keeps one branch checkpoint that a flush restores in a single cycle.
//
// Ports
//   clk, reset           clock, asynchronous active-low reset
//   dec_*                decoded instruction + valid/ready handshake
//   alloc_valid/tag      free reservation-station tag offered by the RS
//   cdb_valid/tag/value  NUM_CDB broadcast ports, port k in slice k
//   ckpt_save/release    take / drop the branch snapshot
//   flush                misprediction: restore the snapshot if one is held
//   ckpt_valid           snapshot currently held
//   iss_*                registered one-cycle dispatch record for the RS
// ---------------------------------------------------------------------------
module rat_rename_ckpt #(
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 4,
    parameter int DATA_W   = 32,
    parameter int NUM_CDB  = 2,
    localparam int REG_W   = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dec_valid,
    output logic                      dec_ready,
    input  logic [REG_W-1:0]          dec_rs1,
    input  logic [REG_W-1:0]          dec_rs2,
    input  logic [REG_W-1:0]          dec_rd,
    input  logic                      dec_has_rd,
    input  logic                      dec_fu,
    input  logic                      alloc_valid,
    input  logic [TAG_W-1:0]          alloc_tag,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_value,
    input  logic                      ckpt_save,
    input  logic                      ckpt_release,
    input  logic                      flush,
    output logic                      ckpt_valid,
    output logic                      iss_valid,
    output logic                      iss_fu,
    output logic [TAG_W-1:0]          iss_tag,
    output logic                      iss_rs1_rdy,
    output logic                      iss_rs2_rdy,
    output logic [TAG_W-1:0]          iss_rs1_tag,
    output logic [TAG_W-1:0]          iss_rs2_tag,
    output logic [DATA_W-1:0]         iss_rs1_val,
    output logic [DATA_W-1:0]         iss_rs2_val
);

    // live table and snapshot
    logic              tbl_vld_q [NUM_REGS];
    logic [TAG_W-1:0]  tbl_tag_q [NUM_REGS];
    logic [DATA_W-1:0] tbl_val_q [NUM_REGS];
    logic              snp_vld_q [NUM_REGS];
    logic [TAG_W-1:0]  snp_tag_q [NUM_REGS];
    logic [DATA_W-1:0] snp_val_q [NUM_REGS];

    // tables after this cycle's CDB (and, for the live table, rename) effects
    logic              tbl_vld_u [NUM_REGS];
    logic [TAG_W-1:0]  tbl_tag_u [NUM_REGS];
    logic [DATA_W-1:0] tbl_val_u [NUM_REGS];
    logic              snp_vld_u [NUM_REGS];
    logic [TAG_W-1:0]  snp_tag_u [NUM_REGS];
    logic [DATA_W-1:0] snp_val_u [NUM_REGS];

    logic              tbl_vld_d [NUM_REGS];
    logic [TAG_W-1:0]  tbl_tag_d [NUM_REGS];
    logic [DATA_W-1:0] tbl_val_d [NUM_REGS];
    logic              snp_vld_d [NUM_REGS];
    logic [TAG_W-1:0]  snp_tag_d [NUM_REGS];
    logic [DATA_W-1:0] snp_val_d [NUM_REGS];

    logic ckpt_valid_q, ckpt_valid_d;

    logic              iss_valid_q, iss_valid_d;
    logic              iss_fu_q, iss_fu_d;
    logic [TAG_W-1:0]  iss_tag_q, iss_tag_d;
    logic              iss_rdy_q [2];
    logic              iss_rdy_d [2];
    logic [TAG_W-1:0]  iss_stag_q [2];
    logic [TAG_W-1:0]  iss_stag_d [2];
    logic [DATA_W-1:0] iss_sval_q [2];
    logic [DATA_W-1:0] iss_sval_d [2];

    logic fire;

    assign dec_ready = !flush && (alloc_valid || !dec_has_rd);
    assign fire      = dec_valid && dec_ready;

    // CDB update of both tables, then rename of the live table. Ports are
    // scanned high to low so the lowest matching port lands last and wins.
    // The rename is applied after the CDB loop so it overrides a same-cycle
    // match on rd.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            tbl_vld_u[i] = tbl_vld_q[i];
            tbl_tag_u[i] = tbl_tag_q[i];
            tbl_val_u[i] = tbl_val_q[i];
            snp_vld_u[i] = snp_vld_q[i];
            snp_tag_u[i] = snp_tag_q[i];
            snp_val_u[i] = snp_val_q[i];
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (!tbl_vld_q[i] && cdb_valid[k] &&
                    cdb_tag[k*TAG_W +: TAG_W] == tbl_tag_q[i]) begin
                    tbl_vld_u[i] = 1'b1;
                    tbl_tag_u[i] = '0;
                    tbl_val_u[i] = cdb_value[k*DATA_W +: DATA_W];
                end
                if (!snp_vld_q[i] && cdb_valid[k] &&
                    cdb_tag[k*TAG_W +: TAG_W] == snp_tag_q[i]) begin
                    snp_vld_u[i] = 1'b1;
                    snp_tag_u[i] = '0;
                    snp_val_u[i] = cdb_value[k*DATA_W +: DATA_W];
                end
            end
        end
        if (fire && dec_has_rd && dec_rd != '0) begin
            tbl_vld_u[dec_rd] = 1'b0;
            tbl_tag_u[dec_rd] = alloc_tag;
        end
    end

    // Checkpoint control: flush > save > release.
    always_comb begin
        ckpt_valid_d = ckpt_valid_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            tbl_vld_d[i] = tbl_vld_u[i];
            tbl_tag_d[i] = tbl_tag_u[i];
            tbl_val_d[i] = tbl_val_u[i];
            snp_vld_d[i] = snp_vld_u[i];
            snp_tag_d[i] = snp_tag_u[i];
            snp_val_d[i] = snp_val_u[i];
        end
        if (flush) begin
            if (ckpt_valid_q) begin
                ckpt_valid_d = 1'b0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    tbl_vld_d[i] = snp_vld_u[i];
                    tbl_tag_d[i] = snp_tag_u[i];
                    tbl_val_d[i] = snp_val_u[i];
                end
            end
        end else if (ckpt_save) begin
            ckpt_valid_d = 1'b1;
            for (int i = 0; i < NUM_REGS; i++) begin
                snp_vld_d[i] = tbl_vld_u[i];
                snp_tag_d[i] = tbl_tag_u[i];
                snp_val_d[i] = tbl_val_u[i];
            end
        end else if (ckpt_release) begin
            ckpt_valid_d = 1'b0;
        end
    end

    // Source read on the pre-rename table, with CDB bypass for waiting entries.
    always_comb begin : src_read
        logic [REG_W-1:0] idx;
        iss_valid_d = fire;
        iss_fu_d    = fire ? dec_fu : 1'b0;
        iss_tag_d   = (fire && dec_has_rd) ? alloc_tag : '0;
        for (int s = 0; s < 2; s++) begin
            idx           = (s == 0) ? dec_rs1 : dec_rs2;
            iss_rdy_d[s]  = 1'b0;
            iss_stag_d[s] = '0;
            iss_sval_d[s] = '0;
            if (fire) begin
                iss_rdy_d[s] = 1'b1;
                if (idx != '0) begin
                    if (tbl_vld_q[idx]) begin
                        iss_sval_d[s] = tbl_val_q[idx];
                    end else begin
                        iss_rdy_d[s]  = 1'b0;
                        iss_stag_d[s] = tbl_tag_q[idx];
                        for (int k = NUM_CDB - 1; k >= 0; k--) begin
                            if (cdb_valid[k] &&
                                cdb_tag[k*TAG_W +: TAG_W] == tbl_tag_q[idx]) begin
                                iss_rdy_d[s]  = 1'b1;
                                iss_stag_d[s] = '0;
                                iss_sval_d[s] = cdb_value[k*DATA_W +: DATA_W];
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                tbl_vld_q[i] <= 1'b1;
                tbl_tag_q[i] <= '0;
                tbl_val_q[i] <= '0;
                snp_vld_q[i] <= 1'b1;
                snp_tag_q[i] <= '0;
                snp_val_q[i] <= '0;
            end
            ckpt_valid_q <= 1'b0;
            iss_valid_q  <= 1'b0;
            iss_fu_q     <= 1'b0;
            iss_tag_q    <= '0;
            for (int s = 0; s < 2; s++) begin
                iss_rdy_q[s]  <= 1'b0;
                iss_stag_q[s] <= '0;
                iss_sval_q[s] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                tbl_vld_q[i] <= tbl_vld_d[i];
                tbl_tag_q[i] <= tbl_tag_d[i];
                tbl_val_q[i] <= tbl_val_d[i];
                snp_vld_q[i] <= snp_vld_d[i];
                snp_tag_q[i] <= snp_tag_d[i];
                snp_val_q[i] <= snp_val_d[i];
            end
            ckpt_valid_q <= ckpt_valid_d;
            iss_valid_q  <= iss_valid_d;
            iss_fu_q     <= iss_fu_d;
            iss_tag_q    <= iss_tag_d;
            for (int s = 0; s < 2; s++) begin
                iss_rdy_q[s]  <= iss_rdy_d[s];
                iss_stag_q[s] <= iss_stag_d[s];
                iss_sval_q[s] <= iss_sval_d[s];
            end
        end
    end

    assign ckpt_valid  = ckpt_valid_q;
    assign iss_valid   = iss_valid_q;
    assign iss_fu      = iss_fu_q;
    assign iss_tag     = iss_tag_q;
    assign iss_rs1_rdy = iss_rdy_q[0];
    assign iss_rs2_rdy = iss_rdy_q[1];
    assign iss_rs1_tag = iss_stag_q[0];
    assign iss_rs2_tag = iss_stag_q[1];
    assign iss_rs1_val = iss_sval_q[0];
    assign iss_rs2_val = iss_sval_q[1];

endmodule

// File: doc/rat_rename_ckpt.md
Name: rat_rename_ckpt

Overview:
- Parametrised register alias table for the Tomasulo front end; successor to the single-issue add/mul RAT.
- Renames one decoded instruction per cycle through a valid/ready handshake and resolves sources to a value or a tag, with same-cycle CDB bypass.
- Accepts NUM_CDB broadcast ports and holds one branch checkpoint, so a misprediction flush restores the mapping in one cycle.
- Sits between the decoder and the add/mul reservation stations.

Parameters:
- NUM_REGS, 32, architectural registers; register 0 is hard-wired to zero. Index width REG_W = $clog2(NUM_REGS).
- TAG_W, 4, reservation-station tag width; tag 0 is reserved as "no tag".
- DATA_W, 32, register value width.
- NUM_CDB, 2, number of common-data-bus broadcast ports.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- dec_valid  in  1  decoded instruction present
- dec_ready  out  1  RAT accepts the instruction this cycle
- dec_rs1, dec_rs2, dec_rd  in  REG_W each  source and destination registers
- dec_has_rd  in  1  instruction writes rd
- dec_fu  in  1  functional unit: 0 = add, 1 = mul (passed through)
- alloc_valid  in  1  a free RS tag is offered
- alloc_tag  in  TAG_W  free RS tag, never 0
- cdb_valid  in  NUM_CDB  per-port broadcast valid
- cdb_tag  in  NUM_CDB*TAG_W  per-port tag, port k at bits [k*TAG_W +: TAG_W]
- cdb_value  in  NUM_CDB*DATA_W  per-port value
- ckpt_save  in  1  snapshot the table (only with a no-rd branch fire, or when idle)
- ckpt_release  in  1  branch resolved correctly; discard the checkpoint
- flush  in  1  misprediction; restore the checkpoint
- ckpt_valid  out  1  checkpoint held
- iss_valid  out  1  registered dispatch pulse
- iss_fu  out  1  registered copy of dec_fu
- iss_tag  out  TAG_W  tag allocated to rd (0 if no rd)
- iss_rs1_rdy, iss_rs2_rdy  out  1  source holds a value
- iss_rs1_tag, iss_rs2_tag  out  TAG_W  producer tag when not ready, else 0
- iss_rs1_val, iss_rs2_val  out  DATA_W  value when ready, else 0

Behaviour:
- Each entry holds VALID, TAG and VALUE. On reset (asynchronous assert, synchronous release):
  - every entry VALID=1, TAG=0, VALUE=0; the checkpoint is cleared and ckpt_valid=0;
  - all iss_* outputs are 0.
- Handshake:
  - dec_ready = !flush && (alloc_valid || !dec_has_rd).
  - fire = dec_valid && dec_ready. The decoder holds its inputs stable until fire.
  - The RS consumes alloc_tag only on a fire with dec_has_rd.
- Source read happens on fire, on the current table (pre-rename), and is registered; outputs are valid the cycle after fire for exactly one cycle.
  - rs==0: ready, value 0.
  - Entry VALID: ready, entry VALUE.
  - Entry invalid and some port k has cdb_valid[k] and a matching tag: ready, that port's value (bypass). The lowest k wins on a duplicate tag.
  - Otherwise: not ready, entry TAG.
  - rs==rd in the same instruction reads the old mapping.
- Rename on fire with dec_has_rd and rd!=0: the entry becomes VALID=0, TAG=alloc_tag. This takes priority over a same-cycle CDB match on that entry. Writes to rd==0 are ignored.
- CDB update: every entry with VALID=0 and a tag equal to an active port's tag becomes VALID=1, value captured, TAG=0. Entries with VALID=1 are never compared.
- iss_valid = registered fire, and is 0 the cycle after a flush-blocked cycle. While iss_valid is high the RS snoops the CDB itself.
- Checkpoint save:
  - ckpt_save copies the post-update table, including this cycle's CDB and rename effects, into the snapshot and sets ckpt_valid.
  - A save while ckpt_valid=1 overwrites the snapshot.
  - While ckpt_valid=1, CDB updates apply identically to snapshot entries.
- ckpt_release clears ckpt_valid.
- Flush:
  - With ckpt_valid=1, the table loads the snapshot with this cycle's CDB updates applied, and ckpt_valid clears.
  - With ckpt_valid=0, the table is unchanged.
  - In both cases fire is blocked that cycle.
- Priority: flush > ckpt_save > ckpt_release; save and release in the same cycle give a save.
- Reset mid-operation discards all mappings, the snapshot and any pending dispatch.

Test Plan:
- After reset, fire with rs1=5, rs2=0, rd=3, alloc_tag=4 -> next cycle iss_valid=1, both sources ready with value 0, iss_tag=4; entry 3 is TAG=4, VALID=0.
- Then fire with rs1=3, rd=3, alloc_tag=6 -> iss_rs1_rdy=0, iss_rs1_tag=4; entry 3 is now TAG=6. A later CDB broadcast of tag 4 with value 0xAA leaves entry 3 invalid.
- With entry 7 at TAG=2, fire rs1=7 in the same cycle as CDB port 1 broadcasting tag=2, value=0x1234 -> iss_rs1_rdy=1, iss_rs1_val=0x1234; entry 7 becomes VALID with value 0x1234.
- CDB port 0 broadcasts tag 3 and port 1 broadcasts tag 5 in the same cycle, with entries 8 and 9 waiting on them -> both entries resolve in that cycle.
- Save with r10 at TAG=2, then rename r10 to tag 9, then CDB tag 2 = 0x55, then flush -> r10 is VALID with value 0x55, ckpt_valid=0, and dec_ready=0 during the flush cycle.
- alloc_valid=0 with dec_has_rd=1 -> dec_ready=0 and no iss_valid. The same stall with dec_has_rd=0 -> the instruction fires.
